serializer_scheduler: RTL and testbench

Round-robin scheduler that shares the single 3-symbol serializer datapath (`serializer_in`) between up to `NUM_REQ` requesters. Each requester presents a 32-bit packed word `[k+8b][k+8b][k+8b]` (k=0 data, k=1 K-code). The scheduler grants one requester at a time, issues the serializer start pulse, and holds the word stable until the serializer reports end-of-transfer. It sits between the requesting engines (Wishbone-side register slaves, test-pattern sources) and the serializer.

---
 rtl/serializer_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/serializer_scheduler.sv | 125 ++++++++++++
 tb/tb_serializer_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_sched_pkg.sv
// Shared types and constants for the serializer scheduler: FSM state encoding,
// default watchdog length and the 9-bit symbol field layout of the packed word.
package serializer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int SYM_W           = 9;
  localparam int K_BIT           = 8;

  // A symbol is a K-code when its top bit is set.
  function automatic logic sym_is_k(input logic [SYM_W-1:0] sym);
    return sym[K_BIT];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set request at or after ptr+1, wrapping,
// returned both as a one-hot grant and as its index.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic          found;
  logic [IW-1:0] cand;

  // Walk the requesters starting just after the last winner.
  always_comb begin
    found = 1'b0;
    idx   = {IW{1'b0}};
    cand  = {IW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        idx   = idx;
      end
    end
    if (found) begin
      grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/serializer_scheduler.sv
// Round-robin owner of the shared serializer: grants one requester, launches the
// transfer, holds the word until end-of-transfer or watchdog abort.
module serializer_scheduler
  import serializer_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      enable_i,
  input  logic [NUM_REQ-1:0]        mask_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      err_o,
  output logic                      ser_start_o,
  output logic [DATA_W-1:0]         ser_data_o,
  input  logic                      ser_eot_i,
  output logic                      busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : {TW{1'b0}};
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_t        state, state_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
  logic                err_nxt, start_nxt, busy_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic [DATA_W-1:0]   words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = data_i[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_i & mask_i),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Next-state and next-output decode; all outputs are registered from these.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    timer_nxt = timer;
    data_nxt  = ser_data_o;
    gnt_nxt   = {NUM_REQ{1'b0}};
    done_nxt  = {NUM_REQ{1'b0}};
    err_nxt   = 1'b0;
    start_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i && (|arb_grant)) begin
          state_nxt = START;
          ptr_nxt   = arb_idx;
          gnt_nxt   = arb_grant;
          start_nxt = 1'b1;
          data_nxt  = words[arb_idx];
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        timer_nxt = {TW{1'b0}};
        state_nxt = WAIT;
      end
      WAIT: begin
        if (ser_eot_i) begin
          state_nxt = DONE;
          done_nxt  = ONE << ptr;
        end else if ((TIMEOUT_CYC > 32'sd0) && (timer == T_LAST)) begin
          state_nxt = DONE;
          done_nxt  = ONE << ptr;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = (timer == T_MAX) ? timer : timer + TW'(1'b1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State, pointer, timer and output registers; reset drops any transfer silently.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state       <= IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      timer       <= {TW{1'b0}};
      gnt_o       <= {NUM_REQ{1'b0}};
      done_o      <= {NUM_REQ{1'b0}};
      err_o       <= 1'b0;
      ser_start_o <= 1'b0;
      ser_data_o  <= {DATA_W{1'b0}};
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      timer       <= timer_nxt;
      gnt_o       <= gnt_nxt;
      done_o      <= done_nxt;
      err_o       <= err_nxt;
      ser_start_o <= start_nxt;
      ser_data_o  <= data_nxt;
      busy_o      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serializer_scheduler.sv
// Bench for serializer_scheduler: vector table for grant order/latency plus
// hand sequences for enable, eot-in-START, async reset and watchdog abort.
module tb_serializer_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    int          idx;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    int         lat;
    int         exp_idx;
    int         exp_lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] mask = 4'b1111;
  logic [N-1:0] req = 4'b0000;
  logic [N-1:0] req_t = 4'b0000;
  logic         eot = 1'b0;
  logic         eot_t = 1'b0;
  logic [31:0]  words [N] = '{32'h0001_BC55, 32'h0000_1A2B, 32'h0102_03FC, 32'h00FF_0F1C};
  logic [N*W-1:0] data;

  logic [N-1:0] gnt, done, gnt_t, done_t;
  logic         err, start, busy, err_t, start_t, busy_t;
  logic [W-1:0] sdata, sdata_t;

  assign data = {words[3], words[2], words[1], words[0]};

  always #5 clk = ~clk;

  serializer_scheduler #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(1024)) dut (
    .CLK_I(clk), .RST_I(rst), .enable_i(enable), .mask_i(mask), .req_i(req),
    .data_i(data), .gnt_o(gnt), .done_o(done), .err_o(err), .ser_start_o(start),
    .ser_data_o(sdata), .ser_eot_i(eot), .busy_o(busy)
  );

  serializer_scheduler #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(16)) dut_t (
    .CLK_I(clk), .RST_I(rst), .enable_i(enable), .mask_i(mask), .req_i(req_t),
    .data_i(data), .gnt_o(gnt_t), .done_o(done_t), .err_o(err_t), .ser_start_o(start_t),
    .ser_data_o(sdata_t), .ser_eot_i(eot_t), .busy_o(busy_t)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic saw_start = 1'b0;
  logic allow_done = 1'b0;
  exp_t sbq [$];
  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int idx);
    exp_t e;
    e.idx  = idx;
    e.word = words[idx];
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] oh(input int idx);
    logic [31:0] one;
    one = 32'd1;
    return one << idx;
  endfunction

  // Advance one clock, sample after the edge, score any start against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    saw_start = 1'b0;
    if (start) begin
      saw_start = 1'b1;
      start_cyc = cyc;
      if (sbq.size() == 0) begin
        check("unexpected_start", {31'd0, start}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("gnt", 32'(gnt), oh(e.idx));
        check("ser_data", sdata, e.word);
        check("busy_at_start", {31'd0, busy}, 32'd1);
      end
    end else if (gnt != 4'b0000) begin
      check("gnt_without_start", 32'(gnt), 32'd0);
    end
    if (done != 4'b0000 && !allow_done) begin
      check("unexpected_done", 32'(done), 32'd0);
    end
  endtask

  task automatic wait_start(input int bound);
    for (int k = 0; k < bound; k++) begin
      step();
      if (saw_start) break;
    end
    if (!saw_start) check("start_wait_timeout", {31'd0, saw_start}, 32'd1);
  endtask

  task automatic eot_and_done(input int idx);
    int e;
    eot = 1'b1;
    e = cyc;
    allow_done = 1'b1;
    step();
    eot = 1'b0;
    allow_done = 1'b0;
    check("done", 32'(done), oh(idx));
    check("err", {31'd0, err}, 32'd0);
    check("done_latency", cyc - e, 32'd1);
  endtask

  task automatic wait_t_start(output int s);
    s = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (start_t) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) check("t_start_wait_timeout", {31'd0, start_t}, 32'd1);
  endtask

  task automatic wait_t_abort(input int s, input int idx);
    for (int k = 0; k < 40; k++) begin
      step();
      if (done_t != 4'b0000) break;
    end
    check("timeout_latency", cyc - s, 32'd17);
    check("timeout_done", 32'(done_t), oh(idx));
    check("timeout_err", {31'd0, err_t}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   ref_cyc;
    int   last_eot;
    int   s;
    int   d;
    int   starts;

    vec[0]  = '{4'b0001, 4'b1111, 20, 0, 1};
    vec[1]  = '{4'b1111, 4'b1111,  4, 1, 3};
    vec[2]  = '{4'b1111, 4'b1111,  3, 2, 3};
    vec[3]  = '{4'b1111, 4'b1111,  5, 3, 3};
    vec[4]  = '{4'b1111, 4'b1111,  1, 0, 3};
    vec[5]  = '{4'b1111, 4'b1111,  2, 1, 3};
    vec[6]  = '{4'b1111, 4'b1010,  3, 3, 3};
    vec[7]  = '{4'b1111, 4'b1010,  3, 1, 3};
    vec[8]  = '{4'b1111, 4'b1010,  3, 3, 3};
    vec[9]  = '{4'b0110, 4'b1111,  2, 1, 3};
    vec[10] = '{4'b0110, 4'b1111,  2, 2, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {gnt, done, err, start, busy}, 32'd0);
    check("rst_ser_data", sdata, 32'd0);
    rst = 1'b0;
    step();
    last_eot = 0;

    // Table: grant order, request/eot-to-start latency, held data.
    for (int i = 0; i < 11; i++) begin
      v = vec[i];
      req  = v.req;
      mask = v.mask;
      ref_cyc = (i == 0) ? cyc : last_eot;
      push_exp(v.exp_idx);
      wait_start(8);
      check("start_latency", start_cyc - ref_cyc, v.exp_lat);
      while (cyc < start_cyc + v.lat) step();
      check("held_data", sdata, words[v.exp_idx]);
      last_eot = cyc;
      eot_and_done(v.exp_idx);
      check("busy_in_done", {31'd0, busy}, 32'd1);
    end
    req = 4'b0000;
    mask = 4'b1111;
    step();
    step();

    // enable dropped mid-WAIT: current transfer finishes, nothing new starts.
    req = 4'b1111;
    push_exp(3);
    wait_start(8);
    s = start_cyc;
    step();
    step();
    enable = 1'b0;
    while (cyc < s + 4) step();
    eot_and_done(3);
    starts = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (saw_start) starts++;
    end
    check("enable_low_no_grant", starts, 32'd0);
    check("enable_low_idle", {31'd0, busy}, 32'd0);
    req = 4'b0000;
    enable = 1'b1;
    step();

    // eot during START must be ignored.
    req = 4'b0001;
    push_exp(0);
    wait_start(8);
    req = 4'b0000;
    eot = 1'b1;
    step();
    eot = 1'b0;
    check("eot_in_start_busy", {31'd0, busy}, 32'd1);
    check("eot_in_start_done", 32'(done), 32'd0);
    step();
    eot_and_done(0);
    step();

    // Asynchronous reset mid-WAIT.
    req = 4'b0100;
    push_exp(2);
    wait_start(8);
    req = 4'b0000;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {gnt, done, err, start, busy}, 32'd0);
    check("async_rst_data", sdata, 32'd0);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    push_exp(0);
    wait_start(8);
    req = 4'b0000;
    step();
    eot_and_done(0);
    step();

    // Watchdog abort on the 16-cycle instance.
    req_t = 4'b0011;
    wait_t_start(s);
    check("t_gnt0", 32'(gnt_t), 32'd1);
    req_t = 4'b0010;
    wait_t_abort(s, 0);
    d = cyc;
    wait_t_start(s);
    check("t_gnt1", 32'(gnt_t), 32'd2);
    check("t_next_latency", s - d, 32'd2);
    req_t = 4'b0000;
    wait_t_abort(s, 1);
    step();
    eot_t = 1'b1;
    step();
    eot_t = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("late_eot_ignored", {gnt_t, done_t, err_t, start_t, busy_t}, 32'd0);
    end
    req_t = 4'b0001;
    wait_t_start(s);
    check("t_gnt_after_late_eot", 32'(gnt_t), 32'd1);
    req_t = 4'b0000;
    wait_t_abort(s, 0);
    step();

    if (sbq.size() != 0) check("scoreboard_leftover", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
